// File: rtl/hog_block_gen_pkg.sv
// Shared HOG constants and the quadrant index used to place cells inside a 2x2 block.
package hog_block_gen_pkg;
    localparam int NUM_BINS  = 9;
    localparam int CELL_PIX  = 64;
    localparam int BLK_CELLS = 4;
    localparam int BIN_I     = 16;
    localparam int BIN_F     = 4;
    localparam int BIN_W     = BIN_I + BIN_F;

    typedef enum logic [1:0] {
        TL = 2'd0,
        TR = 2'd1,
        BL = 2'd2,
        BR = 2'd3
    } quad_e;
endpackage

// File: rtl/hog_block_gen_if.sv
// Cell-in / block-out bus of the HOG block assembler; slave is the assembler's view.
interface hog_block_gen_if #(
    parameter int BIN_W = 20,
    parameter int COL_W = 3,
    parameter int ROW_W = 4
);
    logic                  i_valid;
    logic [9*BIN_W-1:0]    bin;
    logic                  o_valid;
    logic [36*BIN_W-1:0]   block;
    logic [COL_W-1:0]      blk_col;
    logic [ROW_W-1:0]      blk_row;
    logic                  o_last;

    modport master (output i_valid, output bin,
                    input  o_valid, input block, input blk_col, input blk_row, input o_last);
    modport slave  (input  i_valid, input bin,
                    output o_valid, output block, output blk_col, output blk_row, output o_last);
endinterface

// File: rtl/hog_cell_pos_ctr.sv
// Raster cell position counters with row/frame wrap; flags are combinational from the current position.
// Advances once per accepted cell; no backpressure.
module hog_cell_pos_ctr #(
    parameter int CELLS_PER_ROW = 8,
    parameter int CELL_ROWS     = 16,
    parameter int COL_W         = 3,
    parameter int ROW_W         = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_adv,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_blk_rdy,
    output logic             o_last_blk
);
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_adv) begin
            if (r_col == COL_W'(CELLS_PER_ROW - 1)) begin
                r_col <= '0;
                if (r_row == ROW_W'(CELL_ROWS - 1))
                    r_row <= '0;
                else
                    r_row <= r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_blk_rdy  = (r_row != '0) && (r_col != '0);
    assign o_last_blk = (r_row == ROW_W'(CELL_ROWS - 1)) && (r_col == COL_W'(CELLS_PER_ROW - 1));
endmodule

// File: rtl/hog_block_gen.sv
// Assembles overlapping 2x2-cell HOG blocks (stride 1 cell) from raster cell histograms.
// One-cycle registered latency; no backpressure, one block per eligible cell.
module hog_block_gen
    import hog_block_gen_pkg::*;
#(
    parameter int BIN_W         = hog_block_gen_pkg::BIN_W,
    parameter int CELLS_PER_ROW = 8,
    parameter int CELL_ROWS     = 16,
    parameter int COL_W         = 3,
    parameter int ROW_W         = 4
) (
    input  logic          clk,
    input  logic          rst,
    hog_block_gen_if.slave bus
);
    localparam int HW = NUM_BINS * BIN_W;

    logic [COL_W-1:0]        w_col;
    logic [ROW_W-1:0]        w_row;
    logic                    w_blk_rdy;
    logic                    w_last_blk;
    logic [BLK_CELLS*HW-1:0] w_blk;

    logic [HW-1:0]           r_line [CELLS_PER_ROW];
    logic [HW-1:0]           r_up_prev;
    logic [HW-1:0]           r_left;

    logic                    r_o_valid;
    logic                    r_o_last;
    logic [BLK_CELLS*HW-1:0] r_block;
    logic [COL_W-1:0]        r_blk_col;
    logic [ROW_W-1:0]        r_blk_row;

    hog_cell_pos_ctr #(
        .CELLS_PER_ROW (CELLS_PER_ROW),
        .CELL_ROWS     (CELL_ROWS),
        .COL_W         (COL_W),
        .ROW_W         (ROW_W)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .i_adv      (bus.i_valid),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_blk_rdy  (w_blk_rdy),
        .o_last_blk (w_last_blk)
    );

    // r_line[w_col] still holds the cell directly above the incoming one.
    always_comb begin
        w_blk                        = '0;
        w_blk[int'(TL)*HW +: HW]     = r_up_prev;
        w_blk[int'(TR)*HW +: HW]     = r_line[w_col];
        w_blk[int'(BL)*HW +: HW]     = r_left;
        w_blk[int'(BR)*HW +: HW]     = bus.bin;
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.i_valid) begin
            r_line[w_col] <= bus.bin;
            r_up_prev     <= r_line[w_col];
            r_left        <= bus.bin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
            r_block   <= '0;
            r_blk_col <= '0;
            r_blk_row <= '0;
        end else begin
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
            if (bus.i_valid && w_blk_rdy) begin
                r_o_valid <= 1'b1;
                r_o_last  <= w_last_blk;
                r_block   <= w_blk;
                r_blk_col <= w_col - COL_W'(1);
                r_blk_row <= w_row - ROW_W'(1);
            end
        end
    end

    assign bus.o_valid = r_o_valid;
    assign bus.o_last  = r_o_last;
    assign bus.block   = r_block;
    assign bus.blk_col = r_blk_col;
    assign bus.blk_row = r_blk_row;
endmodule

// File: tb/tb_hog_block_gen.sv
// Randomized bench for hog_block_gen against a frame-array reference of 2x2 block assembly.
module tb_hog_block_gen;
    import hog_block_gen_pkg::*;

    localparam int CPR = 8;
    localparam int CR  = 16;
    localparam int HW  = NUM_BINS * BIN_W;
    localparam int BW  = 4 * HW;

    typedef logic [HW-1:0] hist_t;
    typedef logic [BW-1:0] blk_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hog_block_gen_if #(.BIN_W(BIN_W), .COL_W(3), .ROW_W(4)) bus ();

    hog_block_gen #(
        .BIN_W(BIN_W), .CELLS_PER_ROW(CPR), .CELL_ROWS(CR), .COL_W(3), .ROW_W(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    hist_t m_frame [CR][CPR];
    int    m_n;
    blk_t  m_blk;
    int    m_col;
    int    m_row;
    int    pulses;
    int    lasts;

    task automatic chk(input string tag, input blk_t act, input blk_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic hist_t fill(input int n);
        hist_t h;
        for (int k = 0; k < NUM_BINS; k++) h[k*BIN_W +: BIN_W] = BIN_W'(n);
        return h;
    endfunction

    function automatic hist_t rnd();
        hist_t h;
        for (int k = 0; k < NUM_BINS; k++) h[k*BIN_W +: BIN_W] = BIN_W'($urandom);
        return h;
    endfunction

    task automatic compare_outs(input logic ev, input logic el);
        chk("o_valid", blk_t'(bus.o_valid), blk_t'(ev));
        chk("o_last",  blk_t'(bus.o_last),  blk_t'(el));
        chk("block",   bus.block,           m_blk);
        chk("blk_col", blk_t'(bus.blk_col), blk_t'(m_col));
        chk("blk_row", blk_t'(bus.blk_row), blk_t'(m_row));
        if (bus.o_valid) pulses++;
        if (bus.o_last)  lasts++;
    endtask

    // Reference: remember every cell by frame position; a block is the 2x2 window ending at it.
    task automatic step(input logic v, input hist_t c);
        logic ev;
        logic el;
        int   r;
        int   cc;
        @(negedge clk);
        bus.i_valid = v;
        bus.bin     = c;
        @(posedge clk);
        #1;
        ev = 1'b0;
        el = 1'b0;
        if (v) begin
            r  = m_n / CPR;
            cc = m_n % CPR;
            m_frame[r][cc] = c;
            if (r >= 1 && cc >= 1) begin
                ev    = 1'b1;
                el    = (m_n == CPR*CR - 1);
                m_blk = {m_frame[r][cc], m_frame[r][cc-1], m_frame[r-1][cc], m_frame[r-1][cc-1]};
                m_col = cc - 1;
                m_row = r - 1;
            end
            m_n = (m_n + 1) % (CPR*CR);
        end
        compare_outs(ev, el);
    endtask

    task automatic do_reset(input logic with_valid, input int cycles);
        @(negedge clk);
        rst         = 1'b1;
        bus.i_valid = with_valid;
        bus.bin     = rnd();
        repeat (cycles) @(posedge clk);
        #1;
        m_n   = 0;
        m_blk = '0;
        m_col = 0;
        m_row = 0;
        compare_outs(1'b0, 1'b0);
        @(negedge clk);
        rst         = 1'b0;
        bus.i_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.bin     = '0;
        pulses      = 0;
        lasts       = 0;
        do_reset(1'b0, 2);

        // Frame 1: identifiable cells first, random idle gaps between cells.
        for (int n = 0; n < CPR*CR; n++) begin
            if ($urandom_range(0, 2) == 0) step(1'b0, rnd());
            step(1'b1, (n < 18) ? fill(n) : rnd());
            if (n == 9) begin
                chk("b9_valid", blk_t'(bus.o_valid), blk_t'(1));
                chk("b9_q0", blk_t'(bus.block[0*HW +: HW]), blk_t'(fill(0)));
                chk("b9_q1", blk_t'(bus.block[1*HW +: HW]), blk_t'(fill(1)));
                chk("b9_q2", blk_t'(bus.block[2*HW +: HW]), blk_t'(fill(8)));
                chk("b9_q3", blk_t'(bus.block[3*HW +: HW]), blk_t'(fill(9)));
                chk("b9_pos", blk_t'({bus.blk_row, bus.blk_col}), blk_t'(0));
            end
            if (n == 16) chk("b16_novalid", blk_t'(bus.o_valid), blk_t'(0));
            if (n == 17) begin
                chk("b17_q0", blk_t'(bus.block[0*HW +: HW]), blk_t'(fill(8)));
                chk("b17_q1", blk_t'(bus.block[1*HW +: HW]), blk_t'(fill(9)));
                chk("b17_q2", blk_t'(bus.block[2*HW +: HW]), blk_t'(fill(16)));
                chk("b17_q3", blk_t'(bus.block[3*HW +: HW]), blk_t'(fill(17)));
                chk("b17_row", blk_t'(bus.blk_row), blk_t'(1));
            end
        end

        // Frame 2: back-to-back, straight after frame 1.
        pulses = 0;
        lasts  = 0;
        for (int n = 0; n < CPR*CR; n++) begin
            step(1'b1, rnd());
            if (bus.o_last) begin
                chk("last_col", blk_t'(bus.blk_col), blk_t'(6));
                chk("last_row", blk_t'(bus.blk_row), blk_t'(14));
            end
        end
        chk("frame_pulses", blk_t'(pulses), blk_t'(105));
        chk("frame_lasts",  blk_t'(lasts),  blk_t'(1));

        // Partial frame, reset colliding with a valid cell, then a fresh frame start.
        for (int n = 0; n < 21; n++) step(1'b1, rnd());
        do_reset(1'b1, 1);
        for (int n = 0; n < 10; n++) step(1'b1, fill(100 + n));
        chk("mr_valid", blk_t'(bus.o_valid), blk_t'(1));
        chk("mr_q0", blk_t'(bus.block[0*HW +: HW]), blk_t'(fill(100)));
        chk("mr_q1", blk_t'(bus.block[1*HW +: HW]), blk_t'(fill(101)));
        chk("mr_q2", blk_t'(bus.block[2*HW +: HW]), blk_t'(fill(108)));
        chk("mr_q3", blk_t'(bus.block[3*HW +: HW]), blk_t'(fill(109)));
        step(1'b0, rnd());
        step(1'b0, rnd());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
